// File: rtl/seu_readback_monitor_if.sv
// seu_readback_monitor_if
//   Groups the request, storage-cell and result signals of seu_readback_monitor.
//   Parameters must match those of the attached monitor instance.
//   slave  : the monitor side (drives store_d and the res_* fields)
//   master : the controller / readout / storage side
//   Signals: start, pattern_sel, window_len  - check request
//            store_d, store_q                - pattern to cells, readback from cells
//            busy                            - check in progress
//            res_valid, res_ready            - result handshake
//            res_err_cnt, res_any_err, res_first_idx - result fields
interface seu_readback_monitor_if #(
  parameter int WIDTH = 16,
  parameter int WIN_W = 16,
  parameter int CNT_W = 16
);
  localparam int IDX_W = $clog2(WIDTH);

  logic                start;
  logic [1:0]          pattern_sel;
  logic [WIN_W-1:0]    window_len;
  logic [WIDTH-1:0]    store_d;
  logic [WIDTH-1:0]    store_q;
  logic                busy;
  logic                res_valid;
  logic                res_ready;
  logic [CNT_W-1:0]    res_err_cnt;
  logic                res_any_err;
  logic [IDX_W-1:0]    res_first_idx;

  modport slave (
    input  start, pattern_sel, window_len, store_q, res_ready,
    output store_d, busy, res_valid, res_err_cnt, res_any_err, res_first_idx
  );

  modport master (
    output start, pattern_sel, window_len, store_q, res_ready,
    input  store_d, busy, res_valid, res_err_cnt, res_any_err, res_first_idx
  );
endinterface

// File: rtl/seu_readback_monitor.sv
// seu_readback_monitor
//   Drives a known pattern into a bank of WIDTH storage cells, waits SETTLE
//   cycles, then compares the readback for window_len cycles and counts
//   mismatching bits (saturating). The result is offered on a valid/ready port.
//   Ports:
//     clk, rst_n  - clock, asynchronous active-low reset
//     bus         - seu_readback_monitor_if.slave (request, cell data, result)
//     inject_mask - only with SEU_INJECT_EN defined: XORed onto store_d during
//                   COMPARE to create deterministic mismatches for self-test
//   Optional feature macro: SEU_INJECT_EN
module seu_readback_monitor #(
  parameter int WIDTH  = 16,
  parameter int SETTLE = 4,
  parameter int WIN_W  = 16,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef SEU_INJECT_EN
  input  logic [WIDTH-1:0]     inject_mask,
`endif
  seu_readback_monitor_if.slave bus
);
  localparam int IDX_W = $clog2(WIDTH);
  localparam int SUM_W = CNT_W + IDX_W + 1;
  localparam int SET_W = $clog2(SETTLE + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_LOAD    = 2'd1;
  localparam logic [1:0] S_COMPARE = 2'd2;
  localparam logic [1:0] S_REPORT  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [SET_W-1:0] set_cnt_q, set_cnt_d;
  logic [WIN_W-1:0] cmp_cnt_q, cmp_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             any_err_q, any_err_d;
  logic [IDX_W-1:0] first_idx_q, first_idx_d;
  logic             busy_q, busy_d;
  logic             res_valid_q, res_valid_d;

  logic [WIDTH-1:0] pattern;
  logic [WIDTH-1:0] mismatch;
  logic [IDX_W:0]   pop;
  logic [IDX_W-1:0] low_idx;
  logic             low_found;
  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] sat_sum;
  logic [WIDTH-1:0] store_d;

  always_comb begin
    pattern = '0;
    case (sel_q)
      2'd0: pattern = '0;
      2'd1: pattern = '1;
      2'd2: for (int unsigned i = 0; i < WIDTH; i++) pattern[i] = i[0];
      default: for (int unsigned i = 0; i < WIDTH; i++) pattern[i] = ~i[0];
    endcase
  end

  // Expected value is always the clean pattern, even when injection is active.
  assign mismatch = bus.store_q ^ pattern;

  always_comb begin
    pop       = '0;
    low_idx   = '0;
    low_found = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      pop = pop + (IDX_W+1)'(mismatch[i]);
      if (mismatch[i] && !low_found) begin
        low_idx   = IDX_W'(i);
        low_found = 1'b1;
      end
    end
  end

  // Wide sum so the clamp can see any overflow of the CNT_W counter.
  always_comb begin
    sum     = SUM_W'(err_cnt_q) + SUM_W'(pop);
    sat_sum = (sum > SUM_W'({CNT_W{1'b1}})) ? '1 : sum[CNT_W-1:0];
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    win_d       = win_q;
    set_cnt_d   = set_cnt_q;
    cmp_cnt_d   = cmp_cnt_q;
    err_cnt_d   = err_cnt_q;
    any_err_d   = any_err_q;
    first_idx_d = first_idx_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          sel_d       = bus.pattern_sel;
          win_d       = bus.window_len;
          set_cnt_d   = '0;
          err_cnt_d   = '0;
          any_err_d   = 1'b0;
          first_idx_d = '0;
          state_d     = S_LOAD;
        end
      end
      S_LOAD: begin
        if (set_cnt_q == SET_W'(SETTLE - 1)) begin
          // Compare counter starts at 1 so it ends exactly at window_len and
          // never has to represent window_len+1.
          cmp_cnt_d = WIN_W'(1);
          state_d   = (win_q == '0) ? S_REPORT : S_COMPARE;
        end else begin
          set_cnt_d = set_cnt_q + SET_W'(1);
        end
      end
      S_COMPARE: begin
        err_cnt_d = sat_sum;
        if (low_found && !any_err_q) begin
          any_err_d   = 1'b1;
          first_idx_d = low_idx;
        end
        if (cmp_cnt_q == win_q) state_d = S_REPORT;
        else                    cmp_cnt_d = cmp_cnt_q + WIN_W'(1);
      end
      default: begin
        if (bus.res_ready) state_d = S_IDLE;
      end
    endcase
    busy_d      = (state_d != S_IDLE);
    res_valid_d = (state_d == S_REPORT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sel_q       <= '0;
      win_q       <= '0;
      set_cnt_q   <= '0;
      cmp_cnt_q   <= '0;
      err_cnt_q   <= '0;
      any_err_q   <= 1'b0;
      first_idx_q <= '0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      win_q       <= win_d;
      set_cnt_q   <= set_cnt_d;
      cmp_cnt_q   <= cmp_cnt_d;
      err_cnt_q   <= err_cnt_d;
      any_err_q   <= any_err_d;
      first_idx_q <= first_idx_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
    end
  end

  always_comb begin
    store_d = '0;
    if (state_q != S_IDLE) store_d = pattern;
`ifdef SEU_INJECT_EN
    if (state_q == S_COMPARE) store_d = pattern ^ inject_mask;
`endif
  end

  assign bus.store_d       = store_d;
  assign bus.busy          = busy_q;
  assign bus.res_valid     = res_valid_q;
  assign bus.res_err_cnt   = err_cnt_q;
  assign bus.res_any_err   = any_err_q;
  assign bus.res_first_idx = first_idx_q;
endmodule

// File: tb/tb_seu_readback_monitor.sv
// tb_seu_readback_monitor
//   Table-driven checks of seu_readback_monitor with a 2-cycle storage-cell
//   model, plus hand-written saturation, reset and injection sequences.
module tb_seu_readback_monitor;
  localparam int WIDTH  = 16;
  localparam int SETTLE = 4;
  localparam int WIN_W  = 16;
  localparam int CNT_W  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seu_readback_monitor_if #(.WIDTH(WIDTH), .WIN_W(WIN_W), .CNT_W(CNT_W)) bus ();
  seu_readback_monitor_if #(.WIDTH(WIDTH), .WIN_W(WIN_W), .CNT_W(4))     bus_s ();

`ifdef SEU_INJECT_EN
  logic [WIDTH-1:0] inject_mask;
`endif

  seu_readback_monitor #(.WIDTH(WIDTH), .SETTLE(SETTLE), .WIN_W(WIN_W), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef SEU_INJECT_EN
    .inject_mask(inject_mask),
`endif
    .bus(bus)
  );

  seu_readback_monitor #(.WIDTH(WIDTH), .SETTLE(SETTLE), .WIN_W(WIN_W), .CNT_W(4)) dut_sat (
    .clk(clk),
    .rst_n(rst_n),
`ifdef SEU_INJECT_EN
    .inject_mask('0),
`endif
    .bus(bus_s)
  );

  // Storage cell model: store_q = store_d delayed two clocks, plus forced flips.
  logic [WIDTH-1:0] cell1, cell2, flip;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cell1 <= '0;
      cell2 <= '0;
    end else begin
      cell1 <= bus.store_d;
      cell2 <= cell1;
    end
  end
  assign bus.store_q   = cell2 ^ flip;
  assign bus_s.store_q = '0;

  typedef struct {
    logic [1:0]       sel;
    logic [WIN_W-1:0] win;
    logic [WIDTH-1:0] fmask;
    int               fs;
    int               fl;
    logic [WIDTH-1:0] pat;
    int               lat;
    logic [CNT_W-1:0] err;
    logic             any;
    logic [3:0]       idx;
    int               hold;
    bit               poke;
  } vec_t;

  typedef struct {
    int               lat;
    logic [CNT_W-1:0] err;
    logic             any;
    logic [3:0]       idx;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[6];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_store_d"},   bus.store_d, 0);
    check({tag, "_busy"},      bus.busy, 0);
    check({tag, "_valid"},     bus.res_valid, 0);
    check({tag, "_err"},       bus.res_err_cnt, 0);
    check({tag, "_any"},       bus.res_any_err, 0);
    check({tag, "_idx"},       bus.res_first_idx, 0);
  endtask

  // k counts cycles after the start cycle; COMPARE occupies k = 5 .. 4+window.
  task automatic run_vec(input vec_t v);
    exp_t e;
    int   k;
    bit   seen;
    @(posedge clk); #1;
    bus.res_ready   = (v.hold == 0);
    bus.pattern_sel = v.sel;
    bus.window_len  = v.win;
    bus.start       = 1'b1;
    sb.push_back('{v.lat, v.err, v.any, v.idx});
    @(posedge clk); #1;
    bus.start = 1'b0;
    k = 1;
    check("store_d_load", bus.store_d, v.pat);
    check("busy_rise", bus.busy, 1);
    seen = 1'b0;
    while (!seen && k < 300) begin
      flip      = (k >= 5 + v.fs && k < 5 + v.fs + v.fl) ? v.fmask : '0;
      bus.start = v.poke && (k == 2 || k == 6);
      if (bus.res_valid) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        k++;
      end
    end
    bus.start = 1'b0;
    flip      = '0;
    e = sb.pop_front();
    if (!seen) begin
      check("valid_timeout", 0, 1);
    end else begin
      check("latency", k, e.lat);
      check("err_cnt", bus.res_err_cnt, e.err);
      check("any_err", bus.res_any_err, e.any);
      check("first_idx", bus.res_first_idx, e.idx);
      check("store_d_report", bus.store_d, v.pat);
      for (int h = 0; h < v.hold; h++) begin
        bus.start = v.poke && (h % 2 == 0);
        @(posedge clk); #1;
        check("valid_hold", bus.res_valid, 1);
        check("err_hold", bus.res_err_cnt, e.err);
        check("busy_hold", bus.busy, 1);
      end
      // Start coinciding with the handshake must be ignored.
      bus.res_ready = 1'b1;
      bus.start     = v.poke;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("valid_fall", bus.res_valid, 0);
      check("busy_fall", bus.busy, 0);
      check("store_d_idle", bus.store_d, 0);
      @(posedge clk); #1;
      check("idle_no_restart", bus.busy, 0);
      check("err_held_idle", bus.res_err_cnt, e.err);
    end
  endtask

  initial begin
    int k;
    bit seen;
    flip            = '0;
    bus.start       = 1'b0;
    bus.pattern_sel = '0;
    bus.window_len  = '0;
    bus.res_ready   = 1'b1;
    bus_s.start       = 1'b0;
    bus_s.pattern_sel = '0;
    bus_s.window_len  = '0;
    bus_s.res_ready   = 1'b1;
`ifdef SEU_INJECT_EN
    inject_mask = '0;
`endif

    //          sel   win     fmask     fs fl pat       lat err    any   idx   hold poke
    tbl[0] = '{2'd2, 16'd10, 16'h0000, 0, 0, 16'hAAAA, 15, 16'd0, 1'b0, 4'd0,  0, 1'b0};
    tbl[1] = '{2'd1, 16'd8,  16'h0011, 1, 3, 16'hFFFF, 13, 16'd6, 1'b1, 4'd0,  0, 1'b0};
    tbl[2] = '{2'd0, 16'd0,  16'h0000, 0, 0, 16'h0000,  5, 16'd0, 1'b0, 4'd0,  0, 1'b0};
    tbl[3] = '{2'd1, 16'd3,  16'h0000, 0, 0, 16'hFFFF,  8, 16'd0, 1'b0, 4'd0,  5, 1'b1};
    tbl[4] = '{2'd3, 16'd5,  16'h0100, 2, 1, 16'h5555, 10, 16'd1, 1'b1, 4'd8,  0, 1'b0};
    tbl[5] = '{2'd2, 16'd6,  16'hC000, 4, 2, 16'hAAAA, 11, 16'd4, 1'b1, 4'd14, 2, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    check("sat_reset_valid", bus_s.res_valid, 0);
    rst_n = 1'b1;

    foreach (tbl[i]) run_vec(tbl[i]);

    // Reset during the third COMPARE cycle, with flips already counted.
    @(posedge clk); #1;
    bus.pattern_sel = 2'd2;
    bus.window_len  = 16'd10;
    bus.res_ready   = 1'b1;
    bus.start       = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    k = 1;
    while (k < 7) begin
      flip = (k >= 5) ? 16'h0003 : '0;
      @(posedge clk); #1;
      k++;
    end
    check("pre_reset_err", bus.res_err_cnt, 4);
    check("pre_reset_any", bus.res_any_err, 1);
    rst_n = 1'b0;
    flip  = '0;
    #1;
    check_reset_values("midrst");
    @(posedge clk); @(posedge clk); #1;
    check_reset_values("midrst_hold");
    rst_n = 1'b1;
    run_vec(tbl[0]);

    // Saturation on the 4-bit counter instance: 16 bits x 2 cycles = 32 raw.
    @(posedge clk); #1;
    bus_s.pattern_sel = 2'd1;
    bus_s.window_len  = 16'd2;
    bus_s.start       = 1'b1;
    @(posedge clk); #1;
    bus_s.start = 1'b0;
    k = 1;
    seen = 1'b0;
    while (!seen && k < 100) begin
      if (bus_s.res_valid) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        k++;
      end
    end
    check("sat_seen", seen, 1);
    check("sat_latency", k, 7);
    check("sat_err", bus_s.res_err_cnt, 4'hF);
    check("sat_any", bus_s.res_any_err, 1);
    check("sat_idx", bus_s.res_first_idx, 0);
    @(posedge clk); #1;

`ifdef SEU_INJECT_EN
    inject_mask = 16'h8000;
    run_vec('{2'd0, 16'd4, 16'h0000, 0, 0, 16'h0000, 9, 16'd2, 1'b1, 4'd15, 0, 1'b0});
    inject_mask = '0;
`endif

    check("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
